// File: rtl/apu_pkg.sv
// Shared APU constants: noise period table, length-counter table and register bit positions.
// Imported by the square, triangle and noise channels.
package apu_pkg;

    localparam logic [11:0] NOISE_PERIOD [16] = '{
        12'd4,   12'd8,   12'd16,  12'd32,  12'd64,  12'd96,   12'd128,  12'd160,
        12'd202, 12'd254, 12'd380, 12'd508, 12'd762, 12'd1016, 12'd2034, 12'd4068
    };

    localparam logic [7:0] LENGTH_TABLE [32] = '{
        8'd10,  8'd254, 8'd20, 8'd2,  8'd40,  8'd4,  8'd80, 8'd6,
        8'd160, 8'd8,   8'd60, 8'd10, 8'd14,  8'd12, 8'd26, 8'd14,
        8'd12,  8'd16,  8'd24, 8'd18, 8'd48,  8'd20, 8'd96, 8'd22,
        8'd192, 8'd24,  8'd72, 8'd26, 8'd16,  8'd28, 8'd32, 8'd30
    };

    // Single-bit fields of the channel control registers.
    localparam int REG_HALT_BIT  = 5;
    localparam int REG_CONST_BIT = 4;
    localparam int REG_MODE_BIT  = 7;

endpackage

// File: rtl/envelope.sv
// Decay envelope shared by the square and noise channels: a restart arms it, and each
// 240 Hz tick either reloads it or steps the divider and the 15..0 decay level.
module envelope (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_240hz,
    input  logic       restart,
    input  logic       loop,
    input  logic [3:0] period,
    output logic [3:0] decay
);

    logic       start;
    logic [3:0] divider;

    // A restart in the same cycle as a tick only arms start; the tick itself is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start   <= 1'b0;
            decay   <= 4'd0;
            divider <= 4'd0;
        end else if (restart) begin
            start <= 1'b1;
        end else if (enable_240hz) begin
            if (start) begin
                start   <= 1'b0;
                decay   <= 4'd15;
                divider <= period;
            end else if (divider == 4'd0) begin
                divider <= period;
                if (decay != 4'd0) begin
                    decay <= decay - 4'd1;
                end else if (loop) begin
                    decay <= 4'd15;
                end
            end else begin
                divider <= divider - 4'd1;
            end
        end
    end

endmodule

// File: rtl/noise.sv
// APU noise channel: 15-bit LFSR stepped by a table-selected period timer, gated by
// the length counter and scaled by the decay envelope or a constant volume.
import apu_pkg::*;

module noise #(
    parameter logic [14:0] LFSR_SEED   = 15'h0001,
    parameter int          TIMER_WIDTH = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_240hz,
    input  logic       enable_120hz,
    input  logic [7:0] reg_400C,
    input  logic [7:0] reg_400E,
    input  logic [7:0] reg_400F,
    input  logic       reg_change,
    output logic [3:0] noise_out
);

    logic [14:0]            lfsr;
    logic [TIMER_WIDTH-1:0] timer;
    logic [7:0]             length;
    logic [3:0]             decay;
    logic [3:0]             vol;
    logic                   mode;
    logic                   halt;
    logic                   constant;
    logic                   fb;
    logic                   unused_bits;

    assign mode        = reg_400E[REG_MODE_BIT];
    assign halt        = reg_400C[REG_HALT_BIT];
    assign constant    = reg_400C[REG_CONST_BIT];
    assign fb          = lfsr[0] ^ (mode ? lfsr[6] : lfsr[1]);
    assign vol         = constant ? reg_400C[3:0] : decay;
    assign unused_bits = ^{reg_400C[7:6], reg_400E[6:4], reg_400F[2:0]};

    // The period is sampled only on expiry, so a register write never disturbs a running count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr  <= LFSR_SEED;
            timer <= '0;
        end else if (timer == '0) begin
            timer <= TIMER_WIDTH'(NOISE_PERIOD[reg_400E[3:0]] - 12'd1);
            lfsr  <= {fb, lfsr[14:1]};
        end else begin
            timer <= timer - TIMER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            length <= 8'd0;
        end else if (reg_change) begin
            length <= LENGTH_TABLE[reg_400F[7:3]];
        end else if (enable_120hz && length != 8'd0 && !halt) begin
            length <= length - 8'd1;
        end
    end

    envelope u_env (
        .clk          (clk),
        .reset        (reset),
        .enable_240hz (enable_240hz),
        .restart      (reg_change),
        .loop         (halt),
        .period       (reg_400C[3:0]),
        .decay        (decay)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            noise_out <= 4'd0;
        end else begin
            noise_out <= (length == 8'd0 || lfsr[0]) ? 4'd0 : vol;
        end
    end

endmodule

// File: tb/tb_noise.sv
// Directed bench for the noise channel: LFSR/timer stepping, mode 1 period, length gating
// and envelope decay/loop, with internal state observed through the instance hierarchy.
module tb_noise;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable_240hz;
    logic       enable_120hz;
    logic       reg_change;
    logic [7:0] reg_400C;
    logic [7:0] reg_400E;
    logic [7:0] reg_400F;
    logic [3:0] noise_out;

    int checks   = 0;
    int failures = 0;

    logic [14:0] m_lfsr;
    logic [11:0] m_timer;
    logic [11:0] m_period;
    logic        m_mode;
    logic [7:0]  m_len;

    always #5 clk = ~clk;

    noise dut (
        .clk          (clk),
        .reset        (reset),
        .enable_240hz (enable_240hz),
        .enable_120hz (enable_120hz),
        .reg_400C     (reg_400C),
        .reg_400E     (reg_400E),
        .reg_400F     (reg_400F),
        .reg_change   (reg_change),
        .noise_out    (noise_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] lfsr_next(input logic [14:0] s, input logic mode);
        logic f;
        f = s[0] ^ (mode ? s[6] : s[1]);
        return {f, s[14:1]};
    endfunction

    // Reference timer/LFSR step; returns 1 when a shift happened.
    function automatic logic model_step();
        if (m_timer == 12'd0) begin
            m_timer = m_period - 12'd1;
            m_lfsr  = lfsr_next(m_lfsr, m_mode);
            return 1'b1;
        end
        m_timer = m_timer - 12'd1;
        return 1'b0;
    endfunction

    task automatic pulse_change();
        reg_change = 1'b1;
        tick();
        reg_change = 1'b0;
    endtask

    task automatic pulse_120();
        enable_120hz = 1'b1;
        tick();
        enable_120hz = 1'b0;
    endtask

    task automatic pulse_240();
        enable_240hz = 1'b1;
        tick();
        enable_240hz = 1'b0;
    endtask

    initial begin
        logic [3:0]  exp_out;
        logic [3:0]  max_out;
        logic [14:0] s0;
        logic        shifted;
        logic        saw0;
        logic        saw15;
        logic        saw_zero_state;
        int          bad;
        int          shifts;
        int          first_repeat;
        int          exp_decay;

        reset        = 1'b1;
        enable_240hz = 1'b0;
        enable_120hz = 1'b0;
        reg_change   = 1'b0;
        reg_400C     = 8'h3F;
        reg_400E     = 8'h00;
        reg_400F     = 8'h08;
        repeat (3) tick();

        check("reset_out",    32'(noise_out),         32'd0);
        check("reset_lfsr",   32'(dut.lfsr),          32'h0001);
        check("reset_length", 32'(dut.length),        32'd0);
        check("reset_decay",  32'(dut.u_env.decay),   32'd0);
        check("reset_timer",  32'(dut.timer),         32'd0);

        // Mode 0, period 4, constant volume 15; period switches to 32 mid-run.
        reset    = 1'b0;
        m_lfsr   = 15'h0001;
        m_timer  = 12'd0;
        m_period = 12'd4;
        m_mode   = 1'b0;
        m_len    = 8'd0;
        bad      = 0;
        saw0     = 1'b0;
        saw15    = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (i == 60) begin
                reg_400E = 8'h03;
                m_period = 12'd32;
            end
            reg_change = (i == 1);
            exp_out = (m_len == 8'd0 || m_lfsr[0]) ? 4'd0 : 4'd15;
            tick();
            shifted = model_step();
            if (i == 1) m_len = 8'd254;
            if (i == 0) check("first_shift", 32'(dut.lfsr), 32'h4000);
            if (i == 1) check("length_load_254", 32'(dut.length), 32'd254);
            if (dut.lfsr !== m_lfsr || dut.timer !== m_timer || noise_out !== exp_out) bad++;
            if (i > 2 && noise_out == 4'd0)  saw0  = 1'b1;
            if (i > 2 && noise_out == 4'd15) saw15 = 1'b1;
        end
        reg_change = 1'b0;
        check("mode0_seq_mismatches", 32'(bad), 32'd0);
        check("mode0_out_toggles", {30'd0, saw0, saw15}, 32'd3);

        // Reset asserted between clock edges must clear state immediately.
        #2;
        reset = 1'b1;
        #1;
        check("midrun_reset_lfsr",   32'(dut.lfsr),   32'h0001);
        check("midrun_reset_out",    32'(noise_out),  32'd0);
        check("midrun_reset_length", 32'(dut.length), 32'd0);
        check("midrun_reset_timer",  32'(dut.timer),  32'd0);

        // Mode 1 short sequence from the seed, period 4.
        reg_400E = 8'h80;
        tick();
        reset    = 1'b0;
        m_lfsr   = 15'h0001;
        m_timer  = 12'd0;
        m_period = 12'd4;
        m_mode   = 1'b1;
        tick();
        shifted = model_step();
        check("mode1_first_shift", 32'(dut.lfsr), 32'(m_lfsr));
        s0             = m_lfsr;
        shifts         = 0;
        first_repeat   = 0;
        bad            = 0;
        saw_zero_state = 1'b0;
        for (int i = 0; i < 93 * 4; i++) begin
            tick();
            shifted = model_step();
            if (dut.lfsr !== m_lfsr) bad++;
            if (dut.lfsr == 15'h0000) saw_zero_state = 1'b1;
            if (shifted) begin
                shifts++;
                if (first_repeat == 0 && dut.lfsr == s0) first_repeat = shifts;
            end
        end
        check("mode1_seq_mismatches", 32'(bad), 32'd0);
        check("mode1_never_zero", {31'd0, saw_zero_state}, 32'd0);
        check("mode1_period_93_or_31", {31'd0, (first_repeat == 31 || first_repeat == 93)}, 32'd1);
        check("mode1_state_after_93", 32'(dut.lfsr), 32'(s0));

        // Length expiry without halt: index 3 loads 2.
        reg_400C = 8'h1F;
        reg_400F = 8'h18;
        pulse_change();
        check("len_load_2", 32'(dut.length), 32'd2);
        pulse_120();
        check("len_dec_1", 32'(dut.length), 32'd1);
        pulse_120();
        check("len_dec_0", 32'(dut.length), 32'd0);
        pulse_120();
        check("len_hold_0", 32'(dut.length), 32'd0);
        max_out = 4'd0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (noise_out > max_out) max_out = noise_out;
        end
        check("len_expired_silent", 32'(max_out), 32'd0);

        // Halt set: length never decrements.
        reg_400C = 8'h3F;
        pulse_change();
        pulse_120();
        pulse_120();
        check("len_halt_holds", 32'(dut.length), 32'd2);

        // Reload coincident with a 120 Hz tick: reload wins.
        reg_400C     = 8'h1F;
        reg_400F     = 8'h08;
        reg_change   = 1'b1;
        enable_120hz = 1'b1;
        tick();
        reg_change   = 1'b0;
        enable_120hz = 1'b0;
        check("len_reload_beats_tick", 32'(dut.length), 32'd254);
        pulse_120();
        check("len_dec_after_reload", 32'(dut.length), 32'd253);

        // Envelope, V=0, no loop: 15 down to 0, then holds.
        reg_400C = 8'h00;
        pulse_change();
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            pulse_240();
            exp_decay = (k <= 15) ? 15 - k : 0;
            if (k == 0) begin
                check("env_start_15", 32'(dut.u_env.decay), 32'd15);
                max_out = 4'd0;
                for (int i = 0; i < 100; i++) begin
                    tick();
                    if (noise_out > max_out) max_out = noise_out;
                end
                check("env_vol_15_out", 32'(max_out), 32'd15);
            end else if (32'(dut.u_env.decay) != exp_decay) begin
                bad++;
            end
        end
        check("env_decay_seq", 32'(bad), 32'd0);
        check("env_hold_0", 32'(dut.u_env.decay), 32'd0);
        max_out = 4'd0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (noise_out > max_out) max_out = noise_out;
        end
        check("env_vol_0_silent", 32'(max_out), 32'd0);

        // Envelope with loop: wraps from 0 back to 15.
        reg_400C = 8'h20;
        pulse_change();
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            pulse_240();
            exp_decay = (k <= 15) ? 15 - k : 15 - (k - 16);
            if (32'(dut.u_env.decay) != exp_decay) bad++;
        end
        check("env_loop_seq", 32'(bad), 32'd0);
        check("env_loop_after_wrap", 32'(dut.u_env.decay), 32'd12);

        // Restart coincident with a 240 Hz tick: tick dropped, next tick restarts.
        reg_change   = 1'b1;
        enable_240hz = 1'b1;
        tick();
        reg_change   = 1'b0;
        enable_240hz = 1'b0;
        check("env_restart_drops_tick", 32'(dut.u_env.decay), 32'd12);
        pulse_240();
        check("env_restart_next_tick", 32'(dut.u_env.decay), 32'd15);

        // Divider period V=2: decay steps every third tick.
        reg_400C = 8'h02;
        pulse_change();
        pulse_240();
        check("env_div_start", 32'(dut.u_env.decay), 32'd15);
        pulse_240();
        check("env_div_wait1", 32'(dut.u_env.decay), 32'd15);
        pulse_240();
        check("env_div_wait2", 32'(dut.u_env.decay), 32'd15);
        pulse_240();
        check("env_div_step", 32'(dut.u_env.decay), 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noise.md
Name: noise

Overview:
- APU noise channel; fourth-voice companion to the existing square and triangle channels.
- Produces a 4-bit pseudo-random amplitude from a 15-bit LFSR, clocked by a table-selected period timer.
- Amplitude is gated by a length counter and shaped by a decay envelope.
- Runs in the ~1.79 MHz clk domain. noise_out feeds the mixer adder directly upstream of audio_pwm; the mixer width grows to accommodate the extra term.

Parameters:
- LFSR_SEED, 15'h0001, LFSR value loaded at reset; must be nonzero.
- TIMER_WIDTH, 12, width of the period down-counter; must hold 4067.

Ports:
- clk  input  1  APU system clock, ~1.79 MHz.
- reset  input  1  asynchronous, active-high reset.
- enable_240hz  input  1  single-cycle envelope tick from frame.
- enable_120hz  input  1  single-cycle length tick from frame.
- reg_400C  input  8  [5] halt/loop, [4] constant volume, [3:0] volume/envelope period V.
- reg_400E  input  8  [7] mode, [3:0] period index; [6:4] ignored.
- reg_400F  input  8  [7:3] length index; [2:0] ignored.
- reg_change  input  1  single-cycle pulse, clk-synchronous, indicates a register update.
- noise_out  output  4  channel amplitude 0..15.

Behaviour:
- Reset (async assert; deassertion synchronous to clk upstream):
  - lfsr=LFSR_SEED, timer=0, length=0.
  - Envelope state: start=0, decay=0, divider=0.
  - noise_out=0.
- Period table (clk cycles), indexed by reg_400E[3:0]: 4,8,16,32,64,96,128,160,202,254,380,508,762,1016,2034,4068.
- Timer, every clk:
  - timer==0: timer<=P-1 and the LFSR shifts.
  - Otherwise: timer<=timer-1.
  - An LFSR shift therefore occurs every P clocks; the first shift is on the first clk after reset.
  - Register writes never reload the timer; a new period takes effect at the next expiry.
- LFSR shift:
  - fb = lfsr[0] ^ (mode ? lfsr[6] : lfsr[1]).
  - lfsr <= {fb, lfsr[14:1]}.
  - Mode 0 sequence length is 32767; mode 1 is 93 or 31 depending on phase.
  - All-zero state is unreachable from a nonzero seed.
- Length table (index 0..31): 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30. Counter is 8-bit.
- Length counter:
  - reg_change: length<=table[reg_400F[7:3]].
  - Else on enable_120hz with length!=0 and halt==0: decrement.
  - Holds at 0.
  - When reg_change and enable_120hz fall in the same cycle, the reload wins and no decrement is applied.
- Envelope, on reg_change: start<=1.
- Envelope, on enable_240hz:
  - start=1: start<=0, decay<=15, divider<=V.
  - Else if divider==0: divider<=V; then decay>0 gives decay-1, or decay==0 with loop=1 gives decay<=15, otherwise decay holds 0.
  - Else: divider-1.
  - When reg_change and enable_240hz fall in the same cycle, start is set and the tick is processed on the next tick only.
- Volume: vol = constant ? V : decay.
- Output, registered with one-cycle latency from the state it depends on:
  - noise_out <= (length==0 || lfsr[0]==1) ? 0 : vol.
- Reset mid-operation: all state returns to reset values immediately; no partial shift survives.

Decomposition:
- Shared package apu_pkg holds:
  - NOISE_PERIOD[16] table (12-bit entries).
  - LENGTH_TABLE[32] table (8-bit entries), reused by square and triangle.
  - Register bit-position constants.
- One sub-module, envelope: start/divider/decay logic with inputs enable_240hz, restart, loop, period and output decay[3:0]. It is identical to the square channel's envelope and is to be shared by both channels.

Test Plan:
- Reset value check: assert reset mid-run -> noise_out=0 and lfsr=15'h0001 immediately; first clk after release produces lfsr=15'h4000.
- Period and sequence: 400E=0x00, 400C=0x3F, 400F=0x08, pulse reg_change -> LFSR shifts exactly every 4 clk; noise_out toggles between 0 and 15 per lfsr[0]; mode 0 state returns to 15'h4000 after 32767 shifts.
- Mode 1 short sequence: 400E=0x80 from seed -> state repeats with period 93 or 31 shifts; never all-zero.
- Length expiry: 400C=0x1F (no halt), 400F=0x18 (length 2), reg_change -> silent after the second enable_120hz. Repeat with 400C=0x3F -> never silenced.
- Simultaneous write and tick: reg_change coincident with enable_120hz -> length equals the table value (no decrement).
- Envelope decay and loop: 400C=0x10|0 toggled to 0x00 (V=0), reg_change, then 240 Hz ticks -> decay sequence 15,14,...,0 and holds 0. With 400C=0x20 -> wraps from 0 back to 15.
